// File: rtl/arb4_rr_5_pkg.sv
// Shared constants for the arb4_rr_5 round-robin arbiter.
// The state encoding and the default hold limit live here so all users agree on them.
package arb4_rr_5_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } arb_state_e;

  localparam int unsigned MaxHoldDefault = 8;
  localparam int unsigned NumReq         = 4;
  localparam int unsigned DataWidth      = 5;

endpackage

// File: rtl/mux4t1_5.sv
// 4:1 multiplexer, 5-bit wide, used as the arbiter's shared data path.
module mux4t1_5 (
  input  logic [1:0] sel_i,
  input  logic [4:0] d0_i,
  input  logic [4:0] d1_i,
  input  logic [4:0] d2_i,
  input  logic [4:0] d3_i,
  output logic [4:0] y_o
);

  always_comb begin
    y_o = d0_i;
    unique case (sel_i)
      2'd0: y_o = d0_i;
      2'd1: y_o = d1_i;
      2'd2: y_o = d2_i;
      2'd3: y_o = d3_i;
      default: y_o = d0_i;
    endcase
  end

endmodule

// File: rtl/arb4_rr_5.sv
// Four-requester round-robin arbiter with a per-owner hold limit and a muxed data output.
// On release the pointer moves past the old owner and arbitration repeats in the same edge.
module arb4_rr_5 #(
  parameter int unsigned MAX_HOLD = arb4_rr_5_pkg::MaxHoldDefault
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [4:0] I0,
  input  logic [4:0] I1,
  input  logic [4:0] I2,
  input  logic [4:0] I3,
  output logic [3:0] gnt,
  output logic [1:0] s,
  output logic       valid,
  output logic [4:0] o
);

  import arb4_rr_5_pkg::*;

  localparam logic [3:0] HoldLast = 4'(MAX_HOLD - 1);

  arb_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] s_q, s_d;
  logic       valid_q, valid_d;

  logic       release_owner;
  logic [1:0] arb_ptr;
  logic [1:0] idx;
  logic       found;
  logic [1:0] win;
  logic [4:0] mux_y;

  // Search and next-state together so a release can re-arbitrate with the advanced pointer.
  always_comb begin
    release_owner = 1'b0;
    arb_ptr       = ptr_q;
    idx           = 2'd0;
    found         = 1'b0;
    win           = 2'd0;
    state_d       = state_q;
    cnt_d         = cnt_q;
    ptr_d         = ptr_q;
    gnt_d         = gnt_q;
    s_d           = s_q;
    valid_d       = valid_q;

    if (state_q == StGrant) begin
      release_owner = !req[s_q] || (cnt_q == HoldLast);
    end
    if (release_owner) begin
      arb_ptr = s_q + 2'd1;
    end

    for (int k = 0; k < 4; k++) begin
      idx = arb_ptr + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StGrant;
          gnt_d   = 4'b0001 << win;
          s_d     = win;
          valid_d = 1'b1;
          cnt_d   = 4'd0;
        end else begin
          gnt_d   = 4'b0000;
          valid_d = 1'b0;
        end
      end
      StGrant: begin
        if (release_owner) begin
          ptr_d = arb_ptr;
          if (found) begin
            gnt_d   = 4'b0001 << win;
            s_d     = win;
            valid_d = 1'b1;
            cnt_d   = 4'd0;
          end else begin
            state_d = StIdle;
            gnt_d   = 4'b0000;
            valid_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      ptr_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      s_q     <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      valid_q <= valid_d;
    end
  end

  mux4t1_5 u_mux (
    .sel_i (s_q),
    .d0_i  (I0),
    .d1_i  (I1),
    .d2_i  (I2),
    .d3_i  (I3),
    .y_o   (mux_y)
  );

  assign gnt   = gnt_q;
  assign s     = s_q;
  assign valid = valid_q;
  assign o     = valid_q ? mux_y : 5'h00;

endmodule

// File: tb/tb_arb4_rr_5.sv
// Scoreboard bench for arb4_rr_5: directed scenarios followed by random traffic,
// checked against an owner/hold-count model of the arbitration rules.
module tb_arb4_rr_5;

  localparam int MH = 3;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] s;
    logic       valid;
    logic [4:0] o;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [4:0] din [4];
  logic [3:0] gnt;
  logic [1:0] s;
  logic       valid;
  logic [4:0] o;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Model state: owner is -1 when nobody holds the grant.
  int m_owner = -1;
  int m_held  = 0;
  int m_ptr   = 0;
  int m_s     = 0;
  bit m_known = 1'b0;

  arb4_rr_5 #(
    .MAX_HOLD (MH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .I0    (din[0]),
    .I1    (din[1]),
    .I2    (din[2]),
    .I3    (din[3]),
    .gnt   (gnt),
    .s     (s),
    .valid (valid),
    .o     (o)
  );

  always #5 clk = ~clk;

  function automatic int rr_search(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic take(input int w);
    m_owner = w;
    if (w >= 0) begin
      m_held = 1;
      m_s    = w;
    end
  endtask

  task automatic model_edge(input logic r, input logic [3:0] rq);
    if (r) begin
      m_owner = -1;
      m_held  = 0;
      m_ptr   = 0;
      m_s     = 0;
      m_known = 1'b1;
    end else if (m_known) begin
      if (m_owner >= 0) begin
        if (!rq[m_owner] || m_held == MH) begin
          m_ptr = (m_owner + 1) % 4;
          take(rr_search(rq, m_ptr));
        end else begin
          m_held++;
        end
      end else begin
        take(rr_search(rq, m_ptr));
      end
    end
  endtask

  // Apply one cycle of inputs, queue what the outputs must show during it, then clock.
  task automatic step(input logic r, input logic [3:0] rq);
    exp_t e;
    rst = r;
    req = rq;
    if (m_known) begin
      e.valid = (m_owner >= 0);
      e.gnt   = e.valid ? 4'(1 << m_owner) : 4'b0000;
      e.s     = 2'(m_s);
      e.o     = e.valid ? din[m_owner] : 5'h00;
      exp_q.push_back(e);
    end
    @(posedge clk);
    model_edge(r, rq);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if ({gnt, s, valid, o} !== e) begin
        n_err++;
        $display("FAIL outputs t=%0t: got gnt=%b s=%0d valid=%b o=%h, want gnt=%b s=%0d valid=%b o=%h",
                 $time, gnt, s, valid, o, e.gnt, e.s, e.valid, e.o);
      end
    end
  end

  initial begin
    logic [3:0] rq;
    rst = 1'b1;
    req = 4'b0000;
    for (int i = 0; i < 4; i++) din[i] = 5'(i);

    // Reset held with all requests active.
    repeat (3) step(1'b1, 4'b1111);

    // Single request from requester 2 for three cycles.
    din[2] = 5'h05;
    repeat (3) step(1'b0, 4'b0100);
    repeat (3) step(1'b0, 4'b0000);

    // Rotation under constant full request.
    for (int i = 0; i < 4; i++) din[i] = 5'(i);
    repeat (16) step(1'b0, 4'b1111);

    // Lone requester 3 regrants itself after each timeout.
    step(1'b1, 4'b0000);
    repeat (10) step(1'b0, 4'b1000);

    // Owner 1 drops while 0 and 3 request: 3 wins from ptr=2.
    step(1'b1, 4'b0000);
    repeat (2) step(1'b0, 4'b0010);
    repeat (3) step(1'b0, 4'b1001);

    // Reset in the middle of a grant to requester 3.
    step(1'b1, 4'b0000);
    din[3] = 5'h0A;
    repeat (2) step(1'b0, 4'b1000);
    step(1'b1, 4'b1000);
    repeat (4) step(1'b0, 4'b1010);

    // Random traffic with sticky requests and occasional reset.
    rq = 4'b0000;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 4; i++) din[i] = 5'($urandom);
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
      step($urandom_range(0, 49) == 0, rq);
    end

    step(1'b0, 4'b0000);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
